predictor_update_unit: RTL and testbench
========================================

# predictor_update_unit

Commit-side producer of branch-predictor training updates. Sits between the ROB commit port and the IF-stage two-bit predictor. For every committed branch it compares the predicted direction against the resolved direction and buffers an update record. It drains one record per cycle to the predictor, and pulses a redirect request on a misprediction.

## Interface
- DEPTH, 4: update FIFO entries; power of two, 2..16.
- PC_W, 32: PC and target width; matches the data-range width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdy  in  1  global ready; low freezes every register.
- commit_valid  in  1  the ROB commits one instruction this cycle.
- commit_is_branch  in  1  the committed instruction is a B-type branch.
- commit_pc  in  PC_W  PC of the committed instruction.
- commit_pred_taken  in  1  direction predicted at fetch.
- commit_actual_taken  in  1  resolved direction.
- commit_target  in  PC_W  resolved taken target.
- commit_ready  out  1  unit can accept a branch commit this cycle.
- upd_valid  out  1  head record valid (feeds the predictor's "commit pc arrived" input).
- upd_pc  out  PC_W  head record PC.
- upd_hit  out  1  head record prediction was correct.
- upd_taken  out  1  head record resolved direction.
- upd_ready  in  1  predictor accepts the head record this cycle.
- flush_valid  out  1  one-cycle misprediction redirect pulse.
- flush_pc  out  PC_W  correct next PC.

## Operation
- Push condition: rdy & commit_valid & commit_is_branch & commit_ready.
  - Writes the record {commit_pc, commit_pred_taken == commit_actual_taken, commit_actual_taken} at the tail.
- Commits where commit_is_branch = 0 are ignored. No push, no flush.
- commit_ready = (count != DEPTH). It depends only on registered count; there is no full-cycle pass-through.
- Pop condition: rdy & upd_valid & upd_ready. Advances the head.
- upd_valid = (count != 0). upd_pc, upd_hit and upd_taken come straight from the head entry and stay stable while upd_valid & !upd_ready.
- A push and a pop in the same cycle leave count unchanged. This is legal at any occupancy below DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Mispredict: a push with pred != actual sets flush_valid = 1 on the next edge.
  - flush_pc = actual_taken ? commit_target : commit_pc + 4. The addition is modulo 2^PC_W.
  - Otherwise flush_valid clears on the next rdy edge.
- FIFO contents are never dropped on a flush. Committed branches are architectural, so every one of them trains the predictor.
- rdy = 0: pointers, count, flush_valid, flush_pc and counters all hold. Outputs stay stable.
- Reset (any time, including mid-drain):
  - count = 0, pointers = 0, upd_valid = 0, flush_valid = 0, flush_pc = 0.
  - FIFO storage is not cleared.

## Timing
- Push to upd_valid: 1 cycle. A record pushed at edge N is visible from edge N until popped.
- Minimum residency: 1 cycle. There is no same-cycle commit-to-predictor bypass.
- Throughput: 1 push and 1 pop per cycle.
- Commit to flush_valid: 1 cycle. The pulse is exactly 1 rdy-cycle wide, unless back-to-back mispredicts keep it high; then flush_pc updates each cycle.
- Reset deassertion: commit_ready = 1 in the first cycle after rst_n rises.

## Configuration
- PRED_UPDATE_STATS_EN
  - Defined: adds outputs stat_branches and stat_misses, both 32 bits, reset to 0.
    - stat_branches increments on every push.
    - stat_misses increments on pushes with a mispredict.
    - Both wrap at 2^32 and hold while rdy = 0.
  - Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared constants file: PC width, TRUE/FALSE, and the log2 helper for DEPTH.
- One sub-module, upd_fifo: a generic DEPTH × (PC_W+2) synchronous FIFO with push/pop/full/empty.
- The top level holds compare, flush and stats logic.

## Test plan
- Reset mid-traffic: push 3 records, assert rst_n = 0 for 1 cycle → upd_valid = 0, commit_ready = 1, flush_valid = 0.
- Correct prediction: branch pc=0x100, pred = actual = 1, upd_ready = 1 → next cycle upd_valid = 1, upd_pc = 0x100, upd_hit = 1, upd_taken = 1; flush_valid stays 0.
- Mispredict not-taken: pc=0x200, pred = 1, actual = 0 → flush_valid pulses 1 cycle with flush_pc = 0x204; upd_hit = 0.
- Mispredict taken: pc=0xFFFFFFFC, pred = 0, actual = 1, target = 0x40 → flush_pc = 0x40. Repeat with actual = 0 → flush_pc = 0x0 (wrap).
- Full/backpressure: upd_ready = 0, push 4 branches → commit_ready = 0 after the 4th. Then upd_ready = 1 with simultaneous pushes → records drain in order and count stays ≤ 4.
- rdy = 0 for 3 cycles during a pending pop and a flush pulse → all outputs frozen; they resume unchanged when rdy returns. With stats enabled, stat_branches and stat_misses match the pushed totals.

Source files
------------

// File: rtl/predictor_update_unit_pkg.sv
// rtl/predictor_update_unit_pkg.sv - shared constants and log2 helper for the predictor update unit
package predictor_update_unit_pkg;

  localparam int   PC_WIDTH = 32;
  localparam logic TRUE     = 1'b1;
  localparam logic FALSE    = 1'b0;

  // Smallest r with 2**r >= n; used to size FIFO pointers from DEPTH.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/predictor_update_unit_if.sv
// rtl/predictor_update_unit_if.sv - commit, predictor-update and redirect signals of the predictor update unit
interface predictor_update_unit_if #(
  parameter int PC_W = predictor_update_unit_pkg::PC_WIDTH
);

  logic            commit_valid;
  logic            commit_is_branch;
  logic [PC_W-1:0] commit_pc;
  logic            commit_pred_taken;
  logic            commit_actual_taken;
  logic [PC_W-1:0] commit_target;
  logic            commit_ready;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_hit;
  logic            upd_taken;
  logic            upd_ready;

  logic            flush_valid;
  logic [PC_W-1:0] flush_pc;

  // ROB / predictor side
  modport master (
    output commit_valid, commit_is_branch, commit_pc, commit_pred_taken,
           commit_actual_taken, commit_target, upd_ready,
    input  commit_ready, upd_valid, upd_pc, upd_hit, upd_taken,
           flush_valid, flush_pc
  );

  // Update unit side
  modport slave (
    input  commit_valid, commit_is_branch, commit_pc, commit_pred_taken,
           commit_actual_taken, commit_target, upd_ready,
    output commit_ready, upd_valid, upd_pc, upd_hit, upd_taken,
           flush_valid, flush_pc
  );

endinterface

// File: rtl/predictor_update_unit_upd_fifo.sv
// rtl/predictor_update_unit_upd_fifo.sv - generic DEPTH x W synchronous FIFO holding update records
module upd_fifo
  import predictor_update_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int           AW       = log2_ceil(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; callers already gate push/pop with rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/predictor_update_unit.sv
// rtl/predictor_update_unit.sv - commit-side branch predictor training buffer with mispredict redirect; PRED_UPDATE_STATS_EN adds counters
module predictor_update_unit
  import predictor_update_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = PC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  predictor_update_unit_if.slave      bus
`ifdef PRED_UPDATE_STATS_EN
  ,
  output logic [31:0]                 stat_branches,
  output logic [31:0]                 stat_misses
`endif
);

  localparam int RW = PC_W + 2;

  logic            push;
  logic            pop;
  logic            mispredict;
  logic            fifo_full;
  logic            fifo_empty;
  logic [RW-1:0]   wr_rec;
  logic [RW-1:0]   rd_rec;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_valid_q, flush_valid_d;
  logic [PC_W-1:0] flush_pc_q, flush_pc_d;

  assign bus.commit_ready = !fifo_full;
  assign bus.upd_valid    = !fifo_empty;

  assign push = rdy & bus.commit_valid & bus.commit_is_branch & bus.commit_ready;
  assign pop  = rdy & bus.upd_valid & bus.upd_ready;

  assign mispredict  = (bus.commit_pred_taken != bus.commit_actual_taken);
  assign wr_rec      = {bus.commit_pc, !mispredict, bus.commit_actual_taken};
  assign redirect_pc = bus.commit_actual_taken ? bus.commit_target
                                               : bus.commit_pc + PC_W'(4);

  upd_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (pop),
    .rdata_o (rd_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.upd_pc    = rd_rec[RW-1:2];
  assign bus.upd_hit   = rd_rec[1];
  assign bus.upd_taken = rd_rec[0];

  // Redirect pulse: raised by a mispredicted push, dropped on the next active cycle otherwise.
  always_comb begin
    flush_valid_d = flush_valid_q;
    flush_pc_d    = flush_pc_q;
    if (rdy) begin
      flush_valid_d = FALSE;
      if (push && mispredict) begin
        flush_valid_d = TRUE;
        flush_pc_d    = redirect_pc;
      end
    end
  end

  // Registered redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_valid_q <= FALSE;
      flush_pc_q    <= '0;
    end else begin
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

  assign bus.flush_valid = flush_valid_q;
  assign bus.flush_pc    = flush_pc_q;

`ifdef PRED_UPDATE_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_misses_q;

  // Count every accepted branch and the mispredicted subset; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_misses_q   <= '0;
    end else if (push) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict) stat_misses_q <= stat_misses_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_misses   = stat_misses_q;
`endif

endmodule

// File: tb/tb_predictor_update_unit.sv
// tb/tb_predictor_update_unit.sv - self-checking bench for predictor_update_unit with a queue-based reference model
module tb_predictor_update_unit;

  localparam int DEPTH = 4;
  localparam int PW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;

  predictor_update_unit_if #(.PC_W(PW)) bus ();

`ifdef PRED_UPDATE_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;
`endif

  predictor_update_unit #(
    .DEPTH (DEPTH),
    .PC_W  (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
`ifdef PRED_UPDATE_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_misses   (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic          hit;
    logic          taken;
  } rec_t;

  rec_t          mq[$];
  logic          m_fv;
  logic [PW-1:0] m_fpc;
  logic [31:0]   m_br;
  logic [31:0]   m_ms;
  int            checks   = 0;
  int            failures = 0;

  task automatic model_reset();
    mq.delete();
    m_fv  = 1'b0;
    m_fpc = '0;
    m_br  = '0;
    m_ms  = '0;
  endtask

  task automatic drive(input logic v, input logic br, input logic pred, input logic act,
                       input logic [PW-1:0] pc, input logic [PW-1:0] tgt, input logic ur);
    bus.commit_valid        = v;
    bus.commit_is_branch    = br;
    bus.commit_pred_taken   = pred;
    bus.commit_actual_taken = act;
    bus.commit_pc           = pc;
    bus.commit_target       = tgt;
    bus.upd_ready           = ur;
  endtask

  // Advance one clock: the model takes the inputs present before the edge.
  task automatic tick();
    logic do_push, do_pop, mis;
    rec_t r;
    do_push = rdy && bus.commit_valid && bus.commit_is_branch && (mq.size() != DEPTH);
    do_pop  = rdy && (mq.size() != 0) && bus.upd_ready;
    mis     = (bus.commit_pred_taken != bus.commit_actual_taken);
    r.pc    = bus.commit_pc;
    r.hit   = !mis;
    r.taken = bus.commit_actual_taken;
    if (rdy) begin
      m_fv = do_push && mis;
      if (do_push && mis) m_fpc = bus.commit_actual_taken ? bus.commit_target : bus.commit_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(r);
      m_br = m_br + 32'd1;
      if (mis) m_ms = m_ms + 32'd1;
    end
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    checks++; if (bus.commit_ready !== 1'b1) begin failures++; $display("FAIL reset_commit_ready actual=%0b required=1", bus.commit_ready); end
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL reset_upd_valid actual=%0b required=0", bus.upd_valid); end
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL reset_flush_valid actual=%0b required=0", bus.flush_valid); end
    checks++; if (bus.flush_pc !== 32'h0) begin failures++; $display("FAIL reset_flush_pc actual=%h required=0", bus.flush_pc); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, (i != 2), 1'b1, 32'h1000 + 32'(i * 4), 32'h2000, 0);
      tick();
    end
    drive(0, 0, 0, 0, '0, '0, 0);
    checks++; if (bus.upd_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_upd_valid actual=%0b required=1", bus.upd_valid); end
    checks++; if (bus.flush_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_flush_valid actual=%0b required=1", bus.flush_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL midreset_upd_valid actual=%0b required=0", bus.upd_valid); end
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL midreset_flush_valid actual=%0b required=0", bus.flush_valid); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++; if (bus.commit_ready !== 1'b1) begin failures++; $display("FAIL postreset_commit_ready actual=%0b required=1", bus.commit_ready); end
    tick();
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL postreset_upd_valid actual=%0b required=0", bus.upd_valid); end
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL postreset_flush_valid actual=%0b required=0", bus.flush_valid); end
  endtask

  task automatic test_correct();
    drive(1, 1, 1, 1, 32'h100, 32'h0, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0, 1);
    checks++; if (bus.upd_valid !== 1'b1) begin failures++; $display("FAIL correct_upd_valid actual=%0b required=1", bus.upd_valid); end
    checks++; if (bus.upd_pc !== 32'h100) begin failures++; $display("FAIL correct_upd_pc actual=%h required=100", bus.upd_pc); end
    checks++; if (bus.upd_hit !== 1'b1) begin failures++; $display("FAIL correct_upd_hit actual=%0b required=1", bus.upd_hit); end
    checks++; if (bus.upd_taken !== 1'b1) begin failures++; $display("FAIL correct_upd_taken actual=%0b required=1", bus.upd_taken); end
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL correct_flush_valid actual=%0b required=0", bus.flush_valid); end
    tick();
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL correct_popped actual=%0b required=0", bus.upd_valid); end
  endtask

  task automatic test_mispredict();
    drive(1, 1, 1, 0, 32'h200, 32'h3000, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0, 1);
    checks++; if (bus.flush_valid !== 1'b1) begin failures++; $display("FAIL mis_nt_flush_valid actual=%0b required=1", bus.flush_valid); end
    checks++; if (bus.flush_pc !== 32'h204) begin failures++; $display("FAIL mis_nt_flush_pc actual=%h required=204", bus.flush_pc); end
    checks++; if (bus.upd_hit !== 1'b0) begin failures++; $display("FAIL mis_nt_upd_hit actual=%0b required=0", bus.upd_hit); end
    checks++; if (bus.upd_taken !== 1'b0) begin failures++; $display("FAIL mis_nt_upd_taken actual=%0b required=0", bus.upd_taken); end
    tick();
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL mis_nt_pulse_width actual=%0b required=0", bus.flush_valid); end
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h40, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0, 1);
    checks++; if (bus.flush_pc !== 32'h40) begin failures++; $display("FAIL mis_t_flush_pc actual=%h required=40", bus.flush_pc); end
    checks++; if (bus.upd_taken !== 1'b1) begin failures++; $display("FAIL mis_t_upd_taken actual=%0b required=1", bus.upd_taken); end
    tick();
    drive(1, 1, 1, 0, 32'hFFFF_FFFC, 32'h40, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0, 1);
    checks++; if (bus.flush_valid !== 1'b1) begin failures++; $display("FAIL mis_wrap_flush_valid actual=%0b required=1", bus.flush_valid); end
    checks++; if (bus.flush_pc !== 32'h0) begin failures++; $display("FAIL mis_wrap_flush_pc actual=%h required=0", bus.flush_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 1, 32'h300, 32'h500, 1);
    tick();
    checks++; if (bus.flush_pc !== 32'h500) begin failures++; $display("FAIL b2b_first_flush_pc actual=%h required=500", bus.flush_pc); end
    drive(1, 1, 1, 0, 32'h400, 32'h900, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0, 1);
    checks++; if (bus.flush_valid !== 1'b1) begin failures++; $display("FAIL b2b_flush_held actual=%0b required=1", bus.flush_valid); end
    checks++; if (bus.flush_pc !== 32'h404) begin failures++; $display("FAIL b2b_second_flush_pc actual=%h required=404", bus.flush_pc); end
    checks++; if (bus.upd_pc !== 32'h400) begin failures++; $display("FAIL b2b_upd_pc actual=%h required=400", bus.upd_pc); end
    tick();
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL b2b_flush_drop actual=%0b required=0", bus.flush_valid); end
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 0, 32'h800 + 32'(i * 4), '0, 0);
      tick();
    end
    checks++; if (bus.commit_ready !== 1'b0) begin failures++; $display("FAIL full_commit_ready actual=%0b required=0", bus.commit_ready); end
    drive(1, 1, 0, 0, 32'h900, '0, 0);
    tick();
    checks++; if (bus.upd_pc !== 32'h800) begin failures++; $display("FAIL full_head_pc actual=%h required=800", bus.upd_pc); end
    drive(1, 1, 1, 1, 32'hA00, '0, 1);
    tick();
    checks++; if (bus.upd_pc !== 32'h804) begin failures++; $display("FAIL full_first_drain actual=%h required=804", bus.upd_pc); end
    for (int i = 1; i < 8; i++) begin
      drive(1, 1, 1, 1, 32'hA00 + 32'(i * 4), '0, 1);
      tick();
      checks++; if (bus.commit_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL drain_commit_ready actual=%0b required=%0b", bus.commit_ready, mq.size() != DEPTH); end
      checks++; if (mq.size() == 0 || bus.upd_pc !== mq[0].pc) begin failures++; $display("FAIL drain_order actual=%h size=%0d", bus.upd_pc, mq.size()); end
    end
    drain();
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL full_drained actual=%0b required=0", bus.upd_valid); end
  endtask

  task automatic test_rdy_freeze();
    drive(1, 1, 1, 0, 32'h600, 32'h777, 0);
    tick();
    rdy = 1'b0;
    drive(1, 1, 0, 1, 32'h700, 32'h900, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h600) begin failures++; $display("FAIL freeze_upd actual=%0b/%h required=1/600", bus.upd_valid, bus.upd_pc); end
      checks++; if (bus.flush_valid !== 1'b1 || bus.flush_pc !== 32'h604) begin failures++; $display("FAIL freeze_flush actual=%0b/%h required=1/604", bus.flush_valid, bus.flush_pc); end
    end
    rdy = 1'b1;
    drive(0, 0, 0, 0, '0, '0, 1);
    tick();
    checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL resume_flush actual=%0b required=0", bus.flush_valid); end
    checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL resume_pop actual=%0b required=0", bus.upd_valid); end
`ifdef PRED_UPDATE_STATS_EN
    checks++; if (stat_branches !== m_br) begin failures++; $display("FAIL stat_branches actual=%0d required=%0d", stat_branches, m_br); end
    checks++; if (stat_misses !== m_ms) begin failures++; $display("FAIL stat_misses actual=%0d required=%0d", stat_misses, m_ms); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            1'($urandom), $urandom, $urandom, $urandom_range(0, 2) != 0);
      tick();
      checks++; if (bus.commit_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_commit_ready n=%0d actual=%0b", n, bus.commit_ready); end
      checks++; if (bus.upd_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_upd_valid n=%0d actual=%0b", n, bus.upd_valid); end
      if (mq.size() != 0) begin
        checks++;
        if (bus.upd_pc !== mq[0].pc || bus.upd_hit !== mq[0].hit || bus.upd_taken !== mq[0].taken) begin
          failures++;
          $display("FAIL rnd_head n=%0d actual=%h/%0b/%0b required=%h/%0b/%0b", n, bus.upd_pc, bus.upd_hit, bus.upd_taken, mq[0].pc, mq[0].hit, mq[0].taken);
        end
      end
      checks++; if (bus.flush_valid !== m_fv) begin failures++; $display("FAIL rnd_flush_valid n=%0d actual=%0b required=%0b", n, bus.flush_valid, m_fv); end
      checks++; if (bus.flush_pc !== m_fpc) begin failures++; $display("FAIL rnd_flush_pc n=%0d actual=%h required=%h", n, bus.flush_pc, m_fpc); end
    end
    rdy = 1'b1;
`ifdef PRED_UPDATE_STATS_EN
    checks++; if (stat_branches !== m_br) begin failures++; $display("FAIL rnd_stat_branches actual=%0d required=%0d", stat_branches, m_br); end
    checks++; if (stat_misses !== m_ms) begin failures++; $display("FAIL rnd_stat_misses actual=%0d required=%0d", stat_misses, m_ms); end
`endif
  endtask

  initial begin
    drive(0, 0, 0, 0, '0, '0, 0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_correct();
    test_mispredict();
    test_back_to_back();
    test_full();
    test_rdy_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
